// File: rtl/seg7_mux_n.sv
// seg7_mux_n: time-multiplexed N-digit seven-segment scanner.
// The scan alternates a lit SHOW slot per digit with an optional all-off BLANK gap.
// The digit values and enables are captured once per frame, so a frame always shows one
// consistent set of data. Every output comes straight from a flop.
module seg7_mux_n #(
  parameter int N_DIGITS       = 2,
  parameter int DWELL_CYCLES   = 24000,
  parameter int BLANK_CYCLES   = 240,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0,
  localparam int CUR_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [N_DIGITS-1:0]   sel,
  output logic [6:0]            seg_out,
  output logic [CUR_W-1:0]      cur_digit,
  output logic                  frame_tick
);

  // One counter serves both states, so it is sized for the longer of the two intervals.
  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CUR_W-1:0]    LAST_DIGIT = CUR_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                     : {N_DIGITS{1'b0}};

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CUR_W-1:0]      cur_q, cur_d;
  logic [4*N_DIGITS-1:0] snap_q, snap_d;
  logic [N_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;
  logic                  tick_q, tick_d;

  logic                  enter_show;
  logic [CUR_W-1:0]      show_idx;
  logic [CUR_W-1:0]      next_idx;
  logic [3:0]            nib;
  logic                  lit;
  logic [N_DIGITS-1:0]   onehot;

  // Active-high hex mask {g,f,e,d,c,b,a}; b and d are the lowercase forms.
  function automatic logic [6:0] hex_mask(input logic [3:0] v);
    logic [6:0] m;
    case (v)
      4'h0: m = 7'h3F;  4'h1: m = 7'h06;  4'h2: m = 7'h5B;  4'h3: m = 7'h4F;
      4'h4: m = 7'h66;  4'h5: m = 7'h6D;  4'h6: m = 7'h7D;  4'h7: m = 7'h07;
      4'h8: m = 7'h7F;  4'h9: m = 7'h6F;  4'hA: m = 7'h77;  4'hB: m = 7'h7C;
      4'hC: m = 7'h39;  4'hD: m = 7'h5E;  4'hE: m = 7'h79;  default: m = 7'h71;
    endcase
    return m;
  endfunction

  // Wrap the scan index after the last digit; with a single digit this is always 0.
  assign next_idx = (cur_q == LAST_DIGIT) ? '0 : cur_q + CUR_W'(1);

  // State register with asynchronous active-low reset: outputs go dark immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      cur_q     <= '0;
      snap_q    <= '0;
      snap_en_q <= '0;
      sel_q     <= SEL_OFF;
      seg_q     <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      snap_q    <= snap_d;
      snap_en_q <= snap_en_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  // Next state, counter reload, snapshot capture and registered output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    cur_d      = cur_q;
    snap_d     = snap_q;
    snap_en_d  = snap_en_q;
    sel_d      = sel_q;
    seg_d      = seg_q;
    tick_d     = 1'b0;
    enter_show = 1'b0;
    show_idx   = cur_q;
    nib        = 4'h0;
    lit        = 1'b0;
    onehot     = '0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d    = ST_SHOW;
          cnt_d      = '0;
          enter_show = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          cur_d = next_idx;
          if (BLANK_CYCLES == 0) begin
            // No gap: the next digit's slot starts on this very edge.
            enter_show = 1'b1;
            show_idx   = next_idx;
          end else begin
            state_d = ST_BLANK;
            sel_d   = SEL_OFF;
            seg_d   = SEG_OFF;
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (enter_show) begin
      // Digit 0 opens a frame: capture fresh data and use it for this very slot.
      if (show_idx == '0) begin
        snap_d    = digits;
        snap_en_d = digit_en;
        tick_d    = 1'b1;
      end
      for (int i = 0; i < N_DIGITS; i++) begin
        if (show_idx == CUR_W'(i)) begin
          nib       = snap_d[4*i +: 4];
          lit       = snap_en_d[i];
          onehot[i] = 1'b1;
        end
      end
      // A disabled digit still owns its slot, it just stays dark.
      if (lit) begin
        sel_d = SEL_OFF ^ onehot;
        seg_d = hex_mask(nib) ^ SEG_OFF;
      end else begin
        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
      end
    end
  end

  assign sel        = sel_q;
  assign seg_out    = seg_q;
  assign cur_digit  = cur_q;
  assign frame_tick = tick_q;

endmodule
